// File: rtl/booth_seq_ctrl.sv
// Iterative radix-2 Booth multiplier controller: one add/sub-and-shift step per cycle
// over a shared (WIDTH+1)-bit datapath, with request/acknowledge on both sides.
module booth_seq_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_req,
   output logic                 in_ack,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 out_req,
   input  logic                 out_ack,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   a_q, a_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] m_q, m_d;
   logic            q1_q, q1_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   product_q, product_d;

   logic [1:0]      sel_c;
   logic            sub_c;
   logic [AW-1:0]   addend_c;
   logic [AW-1:0]   sum_c;
   logic            last_c;

   // Shared add/subtract: subtraction is A + ~sext(M) + 1
   always_comb begin
      sel_c    = {q_q[0], q1_q};
      sub_c    = (sel_c == 2'b10);
      addend_c = {m_q[WIDTH-1], m_q};
      if (sub_c) begin
         addend_c = ~addend_c;
      end
      sum_c = a_q;
      if (sel_c == 2'b01 || sel_c == 2'b10) begin
         sum_c = a_q + addend_c + AW'(sub_c);
      end
      last_c = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (in_req) state_d = S_CALC;
         S_CALC:  if (last_c) state_d = S_DONE;
         S_DONE:  if (out_ack) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next-state: load on accept, Booth step + arithmetic shift in CALC
   always_comb begin
      a_d       = a_q;
      q_d       = q_q;
      m_d       = m_q;
      q1_d      = q1_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (in_req) begin
               a_d   = '0;
               q_d   = multiplier;
               m_d   = multiplicand;
               q1_d  = 1'b0;
               cnt_d = '0;
            end
         end
         S_CALC: begin
            a_d   = {sum_c[AW-1], sum_c[AW-1:1]};
            q_d   = {sum_c[0], q_q[WIDTH-1:1]};
            q1_d  = q_q[0];
            cnt_d = cnt_q + CW'(1);
            if (last_c) begin
               product_d = {sum_c, q_q[WIDTH-1:1]};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q       <= '0;
         q_q       <= '0;
         m_q       <= '0;
         q1_q      <= 1'b0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         a_q       <= a_d;
         q_q       <= q_d;
         m_q       <= m_d;
         q1_q      <= q1_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   // Handshake outputs decode the state register only
   always_comb begin
      in_ack  = (state_q == S_IDLE);
      out_req = (state_q == S_DONE);
      busy    = (state_q != S_IDLE);
      product = product_q;
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl at WIDTH=8: expected products are queued on
// accept and compared when the product handshake completes.
module tb_booth_seq_ctrl;

   localparam int unsigned W = 8;

   logic           clk;
   logic           rst_n;
   logic           in_req;
   logic           in_ack;
   logic [W-1:0]   multiplicand;
   logic [W-1:0]   multiplier;
   logic           out_req;
   logic           out_ack;
   logic [2*W-1:0] product;
   logic           busy;

   int n_vec = 0;
   int n_err = 0;
   logic [2*W-1:0] sb[$];

   booth_seq_ctrl #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_req       (in_req),
      .in_ack       (in_ack),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .out_req      (out_req),
      .out_ack      (out_ack),
      .product      (product),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_prod(input int m, input int q);
      int p;
      p = m * q;
      return p[2*W-1:0];
   endfunction

   // Completed product handshakes are checked against the scoreboard in order
   always @(negedge clk) begin
      if (rst_n && out_req && out_ack) begin
         if (sb.size() == 0) begin
            chk("unexpected_out_req", 32'(product), 32'hDEAD);
         end else begin
            logic [2*W-1:0] e;
            e = sb.pop_front();
            chk("product", 32'(product), 32'(e));
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ack && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      chk("idle_wait", 32'(in_ack), 32'd1);
   endtask

   // One multiply; hold>0 keeps out_ack low that many cycles after out_req rises
   task automatic run_op(input int m, input int q, input int hold);
      int n;
      logic [2*W-1:0] e;
      e = ref_prod(m, q);
      out_ack = (hold == 0);
      wait_idle();
      multiplicand = W'(m);
      multiplier   = W'(q);
      in_req       = 1'b1;
      @(posedge clk); #1;
      in_req = 1'b0;
      sb.push_back(e);
      multiplicand = ~multiplicand;
      multiplier   = multiplier + 8'd1;
      n = 0;
      while (!out_req && n < 40) begin
         in_req = (hold > 0) && (n == 3);
         @(posedge clk); #1;
         n++;
      end
      in_req = 1'b0;
      chk("latency", 32'(n), 32'd8);
      if (hold == 0) begin
         @(posedge clk); #1;
         chk("out_req_one_cycle", 32'(out_req), 32'd0);
         chk("in_ack_after_done", 32'(in_ack), 32'd1);
      end else begin
         for (int i = 0; i < hold; i++) begin
            chk("bp_out_req", 32'(out_req), 32'd1);
            chk("bp_product", 32'(product), 32'(e));
            chk("bp_in_ack", 32'(in_ack), 32'd0);
            in_req = 1'b1;
            @(posedge clk); #1;
         end
         in_req  = 1'b0;
         chk("bp_still_done", 32'(out_req), 32'd1);
         out_ack = 1'b1;
         @(posedge clk); #1;
         chk("bp_released", 32'(out_req), 32'd0);
         chk("bp_idle", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      in_req       = 1'b0;
      out_ack      = 1'b0;
      multiplicand = '0;
      multiplier   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ack", 32'(in_ack), 32'd1);
      chk("rst_out_req", 32'(out_req), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_product", 32'(product), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(3, 5, 0);
      chk("prod_3x5_held", 32'(product), 32'h000F);
      run_op(-7, 6, 0);
      chk("prod_m7x6_held", 32'(product), 32'hFFD6);
      run_op(-128, -128, 0);
      chk("prod_min_sq", 32'(product), 32'h4000);
      run_op(127, -128, 0);
      chk("prod_max_min", 32'(product), 32'hC080);
      run_op(0, -1, 0);
      chk("prod_zero", 32'(product), 32'h0000);
      run_op(-100, 77, 3);

      // Back-to-back with in_req held high across both operations
      out_ack = 1'b1;
      wait_idle();
      multiplicand = 8'd2;
      multiplier   = 8'd2;
      in_req       = 1'b1;
      @(posedge clk); #1;
      sb.push_back(16'h0004);
      multiplicand = 8'hFF;
      multiplier   = 8'hFF;
      repeat (7) @(posedge clk);
      #1;
      chk("b2b_not_yet", 32'(out_req), 32'd0);
      @(posedge clk); #1;
      chk("b2b_first_done", 32'(out_req), 32'd1);
      @(posedge clk); #1;
      chk("b2b_idle_edge", 32'(in_ack), 32'd1);
      chk("b2b_idle_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      sb.push_back(16'h0001);
      in_req = 1'b0;
      chk("b2b_second_accept", 32'(busy), 32'd1);
      repeat (7) @(posedge clk);
      #1;
      chk("b2b_second_not_yet", 32'(out_req), 32'd0);
      @(posedge clk); #1;
      chk("b2b_second_done", 32'(out_req), 32'd1);
      chk("b2b_second_prod", 32'(product), 32'h0001);
      @(posedge clk); #1;

      // Reset in the middle of CALC aborts the operation
      wait_idle();
      multiplicand = 8'd5;
      multiplier   = 8'hFD;
      in_req       = 1'b1;
      @(posedge clk); #1;
      in_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk("abort_in_ack", 32'(in_ack), 32'd1);
      chk("abort_out_req", 32'(out_req), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("abort_stays_idle", 32'(out_req), 32'd0);
      run_op(9, 9, 0);
      chk("prod_9x9", 32'(product), 32'h0051);

      for (int i = 0; i < 12; i++) begin
         int a;
         int b;
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         run_op(a, b, (i % 3 == 0) ? 1 : 0);
      end

      repeat (2) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/booth_seq_ctrl.md
# booth_seq_ctrl

Sequencing controller for the Booth multiplier pipeline. It drives a single shared (WIDTH+1)-bit add/subtract datapath, built from the team's full-adder cells, through the iterative radix-2 Booth recurrence. A request/acknowledge handshake accepts signed operands. After WIDTH iteration cycles the block presents a registered 2·WIDTH-bit signed product, held under its own request/acknowledge handshake.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2·WIDTH bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_req  input  1  operand-valid request from upstream stage.
- in_ack  output  1  high while idle; operands are accepted on the edge where in_req && in_ack.
- multiplicand  input  WIDTH  signed two's-complement operand M.
- multiplier  input  WIDTH  signed two's-complement operand Q.
- out_req  output  1  product-valid request to downstream stage.
- out_ack  input  1  downstream acceptance of the product.
- product  output  2·WIDTH  signed product; registered.
- busy  output  1  high in CALC or DONE.

## Operation
- State machine: IDLE, CALC, DONE.
- IDLE:
  - in_ack=1.
  - On in_req=1: load M, Q, A=0 (WIDTH+1 bits), q_1=0, cnt=0, and go to CALC.
- CALC, one Booth step per cycle, selected by {Q[0],q_1}:
  - 01: A=A+sext(M).
  - 10: A=A−sext(M), implemented as A + ~sext(M) with carry-in 1.
  - 00 or 11: A unchanged.
  - Then arithmetic shift right of {A,Q,q_1} by one, with A's MSB replicated.
  - cnt increments each step. After the step with cnt=WIDTH−1, go to DONE and load product = low 2·WIDTH bits of {A,Q} after that final shift.
- A is WIDTH+1 bits wide so that subtracting the most negative M cannot overflow. The product is exact for every operand pair, including −2^(WIDTH−1)·−2^(WIDTH−1).
- DONE:
  - out_req=1 and product stable.
  - On out_ack=1, go to IDLE. out_req drops on the same edge.
- in_req is ignored outside IDLE. multiplicand and multiplier are sampled only on the accept edge and may change afterwards.
- product holds its last value in IDLE and CALC. It changes only on entry to DONE.
- Reset at any time, including mid-CALC or in DONE: the operation aborts immediately and no out_req is produced for it. The block returns to IDLE.

## Timing
- Reset values:
  - State IDLE.
  - in_ack=1, out_req=0, busy=0, product=0.
  - Internal A, Q, M, q_1 and cnt all 0.
- Accept edge T0 → out_req rises at edge T0+WIDTH, i.e. WIDTH cycles after acceptance.
- out_req stays high for at least one cycle, even if out_ack is already high on DONE entry.
- DONE → IDLE on the first edge with out_ack=1. in_ack rises on that same edge.
- Back-to-back: next accept no earlier than one cycle after the DONE→IDLE edge. Minimum initiation interval is WIDTH+2 cycles.
- in_ack, out_req and busy are decoded from registered state only, with no combinational path from any input.

## Test plan
- WIDTH=8: multiplicand=3, multiplier=5, out_ack tied high → product=16'h000F; out_req high exactly 8 cycles after accept, for 1 cycle.
- Signed case: −7 × 6 → product=16'hFFD6.
- Corner cases:
  - −128 × −128 → 16'h4000.
  - 127 × −128 → 16'hC080.
  - 0 × −1 → 16'h0000.
- Backpressure: out_ack held low 3 cycles after out_req → out_req and product stable throughout; in_ack=0; in_req pulses during CALC and DONE are ignored.
- Back-to-back: 2 × 2 then −1 × −1 with in_req held high → products 16'h0004 then 16'h0001; second accept occurs one cycle after the first DONE→IDLE edge.
- Reset: assert rst_n=0 at CALC cycle 4 → in_ack=1, out_req=0, product=0 immediately. A new request 9 × 9 then yields 16'h0051.
